// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - MDU command/result interface between the E stage and mdu_ctrl
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, md_use_d,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, md_use_d,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MIPS multiply/divide controller owning HI/LO; optional madd/msub under MDU_MADD_EN
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] LP_MULT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV  = 4'(DIV_CYCLES);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic [31:0] r_res_hi, w_res_hi_nxt;
    logic [31:0] r_res_lo, w_res_lo_nxt;
    logic        r_res_we, w_res_we_nxt;

    // Result datapath: computed from the operands seen at the issue edge and
    // parked in r_res_* until the counter expires.
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_div0;
    logic [31:0]        w_rt_safe;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic [31:0]        w_quo_u;
    logic [31:0]        w_rem_u;
    logic               w_long_op;

    assign w_prod_s  = $signed({{32{bus.rs_val[31]}}, bus.rs_val}) *
                       $signed({{32{bus.rt_val[31]}}, bus.rt_val});
    assign w_prod_u  = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
    assign w_div0    = (bus.rt_val == 32'd0);
    // Divisor forced non-zero so the divider never produces X; the result
    // is discarded anyway on divide-by-zero.
    assign w_rt_safe = w_div0 ? 32'd1 : bus.rt_val;
    assign w_quo_s   = $signed(bus.rs_val) / $signed(w_rt_safe);
    assign w_rem_s   = $signed(bus.rs_val) % $signed(w_rt_safe);
    assign w_quo_u   = bus.rs_val / w_rt_safe;
    assign w_rem_u   = bus.rs_val % w_rt_safe;

`ifdef MDU_MADD_EN
    logic [63:0] w_madd;
    logic [63:0] w_msub;
    assign w_madd    = {r_hi, r_lo} + w_prod_s;
    assign w_msub    = {r_hi, r_lo} - w_prod_s;
    assign w_long_op = (bus.op <= 3'd3) || (bus.op >= 3'd6);
`else
    assign w_long_op = (bus.op <= 3'd3);
`endif

    // State, counter, HI/LO and pending result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_we <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_res_hi <= w_res_hi_nxt;
            r_res_lo <= w_res_lo_nxt;
            r_res_we <= w_res_we_nxt;
        end
    end

    // Next-state: issue in IDLE, count down in BUSY, commit on the last cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_res_hi_nxt = r_res_hi;
        w_res_lo_nxt = r_res_lo;
        w_res_we_nxt = r_res_we;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        3'd0: begin
                            {w_res_hi_nxt, w_res_lo_nxt} = w_prod_s;
                            w_res_we_nxt = 1'b1;
                            w_cnt_nxt    = LP_MULT;
                            w_state_nxt  = S_BUSY;
                        end
                        3'd1: begin
                            {w_res_hi_nxt, w_res_lo_nxt} = w_prod_u;
                            w_res_we_nxt = 1'b1;
                            w_cnt_nxt    = LP_MULT;
                            w_state_nxt  = S_BUSY;
                        end
                        3'd2: begin
                            w_res_hi_nxt = w_rem_s;
                            w_res_lo_nxt = w_quo_s;
                            w_res_we_nxt = !w_div0;
                            w_cnt_nxt    = LP_DIV;
                            w_state_nxt  = S_BUSY;
                        end
                        3'd3: begin
                            w_res_hi_nxt = w_rem_u;
                            w_res_lo_nxt = w_quo_u;
                            w_res_we_nxt = !w_div0;
                            w_cnt_nxt    = LP_DIV;
                            w_state_nxt  = S_BUSY;
                        end
                        3'd4: w_hi_nxt = bus.rs_val;
                        3'd5: w_lo_nxt = bus.rs_val;
`ifdef MDU_MADD_EN
                        3'd6: begin
                            {w_res_hi_nxt, w_res_lo_nxt} = w_madd;
                            w_res_we_nxt = 1'b1;
                            w_cnt_nxt    = LP_MULT;
                            w_state_nxt  = S_BUSY;
                        end
                        3'd7: begin
                            {w_res_hi_nxt, w_res_lo_nxt} = w_msub;
                            w_res_we_nxt = 1'b1;
                            w_cnt_nxt    = LP_MULT;
                            w_state_nxt  = S_BUSY;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // New starts are ignored here; the pipeline stall keeps them out.
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_IDLE;
                    if (r_res_we) begin
                        w_hi_nxt = r_res_hi;
                        w_lo_nxt = r_res_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy  = (r_state == S_BUSY);
    assign bus.stall = bus.md_use_d & (bus.busy | (bus.start & w_long_op));
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl against an arithmetic reference model
module tb_mdu_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_long(input logic [2:0] op);
`ifdef MDU_MADD_EN
        return (op <= 3'd3) || (op >= 3'd6);
`else
        return (op <= 3'd3);
`endif
    endfunction

    // Architectural effect of one command on HI/LO, and how long it keeps busy high
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int cyc);
        int sa, sb;
        longint sp;
        longint unsigned up, acc;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        cyc = 0;
        case (op)
            3'd0: begin {m_hi, m_lo} = sp; cyc = 5; end
            3'd1: begin {m_hi, m_lo} = up; cyc = 5; end
            3'd2: begin
                if (b != 0) begin m_lo = sa / sb; m_hi = sa % sb; end
                cyc = 10;
            end
            3'd3: begin
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
                cyc = 10;
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: begin
`ifdef MDU_MADD_EN
                acc = {m_hi, m_lo};
                if (op == 3'd6) acc = acc + longint'(sp);
                else            acc = acc - longint'(sp);
                {m_hi, m_lo} = acc;
                cyc = 5;
`else
                acc = 0;
`endif
            end
        endcase
    endtask

    // Issue one command, optionally inject a stray start while busy, then check result and timing
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mu, input bit inject);
        int exp_cyc;
        int n;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.rs_val   = a;
        bus.rt_val   = b;
        bus.md_use_d = mu;
        #1;
        chk("issue_stall", bus.stall, mu & is_long(op));
        model_apply(op, a, b, exp_cyc);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            chk("busy_stall", bus.stall, mu);
            if (n == 0) begin
                chk("hold_hi", bus.hi, old_hi);
                chk("hold_lo", bus.lo, old_lo);
            end
            if (inject && n == 1) begin
                bus.start  = 1'b1;
                bus.op     = 3'($urandom_range(0, 7));
                bus.rs_val = $urandom;
                bus.rt_val = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("busy_cycles", 64'(n), 64'(exp_cyc));
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
        chk("idle_stall", bus.stall, 1'b0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        checks = 0;
        errors = 0;
        m_hi = 0;
        m_lo = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.op       = 3'd0;
        bus.rs_val   = 32'd0;
        bus.rt_val   = 32'd0;
        bus.md_use_d = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_stall", bus.stall, 1'b0);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        chk("mult_hi_const", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo_const", bus.lo, 32'hFFFFFFFA);
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
        chk("multu_hi_const", bus.hi, 32'h00000001);
        chk("multu_lo_const", bus.lo, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        chk("div_hi_const", bus.hi, 32'hFFFFFFFF);
        chk("div_lo_const", bus.lo, 32'hFFFFFFFD);
        run_op(3'd3, 32'd7, 32'd0, 1'b0, 1'b0);
        chk("div0_hi_const", bus.hi, 32'hFFFFFFFF);
        chk("div0_lo_const", bus.lo, 32'hFFFFFFFD);
        run_op(3'd0, 32'd1234, 32'hFFFFFF00, 1'b1, 1'b1);
        run_op(3'd4, 32'h12345678, 32'd0, 1'b1, 1'b0);
        chk("mthi_const", bus.hi, 32'h12345678);
        run_op(3'd5, 32'h9ABCDEF0, 32'd0, 1'b1, 1'b0);
        chk("mtlo_const", bus.lo, 32'h9ABCDEF0);

        // Reset in the third busy cycle of a divide aborts it
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 3'd2;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("div_busy_c3", bus.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 0;
        m_lo = 0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_no_commit_hi", bus.hi, 32'd0);
        chk("abort_no_commit_lo", bus.lo, 32'd0);

        // Optional accumulate ops (or their absence)
        run_op(3'd5, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op(3'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        run_op(3'd6, 32'd3, 32'd4, 1'b1, 1'b0);
`ifdef MDU_MADD_EN
        chk("madd_lo_const", bus.lo, 32'd17);
`else
        chk("op6_noop_lo", bus.lo, 32'd5);
`endif
        chk("op6_hi_const", bus.hi, 32'd0);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            if (rop == 3'd2 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Start in the same cycle as reset: reset wins
        @(negedge clk);
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.op       = 3'd0;
        bus.rs_val   = 32'd5;
        bus.rt_val   = 32'd5;
        bus.md_use_d = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy", bus.busy, 1'b0);
        chk("rst_start_hi", bus.hi, 32'd0);
        chk("rst_start_lo", bus.lo, 32'd0);
        @(negedge clk);
        chk("rst_start_busy2", bus.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
